iob_fifo2stream: RTL

Read-side drain stage that sits directly downstream of the asynchronous FIFO's read port, in the read clock domain. It issues FIFO reads, absorbs the FIFO memory's one-cycle read latency, and presents the words as a valid/ready stream through a 2-entry skid buffer. The stream sustains one word per cycle under continuous `m_ready`. An optional packet counter marks packet boundaries.

---
 rtl/iob_fifo2stream_if.sv | 34 +++
 rtl/iob_fifo2stream.sv | 122 ++++++++++++
 2 files changed

// File: rtl/iob_fifo2stream_if.sv
// iob_fifo2stream_if
//   Bundles the FIFO read-port signals and the outgoing valid/ready stream
//   of the iob_fifo2stream drain stage.
//   master : drain-stage view (issues FIFO reads, drives the stream)
//   slave  : environment view (FIFO read port + downstream consumer)
//   Signals:
//     fifo_r_en    FIFO read request
//     fifo_r_data  FIFO read data, one cycle after fifo_r_en
//     fifo_r_empty FIFO empty flag
//     m_valid      stream valid
//     m_ready      stream ready
//     m_data       stream data
//     m_last       last word of a packet
interface iob_fifo2stream_if #(
    parameter int DATA_W = 32
);
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_r_data;
    logic              fifo_r_empty;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output fifo_r_en, m_valid, m_data, m_last,
        input  fifo_r_data, fifo_r_empty, m_ready
    );

    modport slave (
        input  fifo_r_en, m_valid, m_data, m_last,
        output fifo_r_data, fifo_r_empty, m_ready
    );
endinterface

// File: rtl/iob_fifo2stream.sv
// iob_fifo2stream
//   Read-side drain stage for an asynchronous FIFO (read clock domain).
//   Issues FIFO reads, absorbs the one-cycle read latency of the FIFO
//   memory and presents the words as a valid/ready stream through a
//   2-entry skid buffer. Sustains one word per cycle.
//   Ports:
//     clk    read-domain clock (same as FIFO r_clk)
//     rst_n  asynchronous active-low reset
//     en     allow new FIFO reads
//     len    packet length in words (packet marking only)
//     bus    iob_fifo2stream_if.master: FIFO read port + output stream
//     count  words accepted downstream, wraps modulo 2^LEN_W
//   Optional feature: define FIFO2STREAM_LAST_EN to build the packet beat
//   counter that drives m_last; otherwise m_last is tied low and len is
//   ignored.
module iob_fifo2stream #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [LEN_W-1:0]     len,
    iob_fifo2stream_if.master    bus,
    output logic [LEN_W-1:0]     count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t              occ;
    logic              inflight;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              pop;
    logic [2:0]        level_next;

    assign bus.m_valid = (occ != EMPTY);
    assign bus.m_data  = head;
    assign pop         = bus.m_valid & bus.m_ready;

    // Occupancy after this cycle's landing and pop; a new read is allowed
    // only if its word will still find a free slot when it lands.
    // pop implies occ >= 1, so the subtraction never underflows.
    assign level_next = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign bus.fifo_r_en = en & ~bus.fifo_r_empty & (level_next < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= bus.fifo_r_en;
            if (pop) begin
                count <= count + LEN_W'(1);
            end
            case (occ)
                EMPTY: begin
                    if (inflight) begin
                        head <= bus.fifo_r_data;
                        occ  <= ONE;
                    end
                end
                ONE: begin
                    if (inflight && pop) begin
                        // Head leaves this cycle; the landing word replaces it.
                        head <= bus.fifo_r_data;
                    end else if (inflight) begin
                        tail <= bus.fifo_r_data;
                        occ  <= TWO;
                    end else if (pop) begin
                        occ  <= EMPTY;
                    end
                end
                TWO: begin
                    // A landing without a pop cannot occur here: the read
                    // issue condition forbids it.
                    if (pop) begin
                        head <= tail;
                        if (inflight) begin
                            tail <= bus.fifo_r_data;
                        end else begin
                            occ  <= ONE;
                        end
                    end
                end
                default: occ <= EMPTY;
            endcase
        end
    end

`ifdef FIFO2STREAM_LAST_EN
    logic [LEN_W-1:0] beat;

    // len == 0 disables packet marking entirely.
    assign bus.m_last = bus.m_valid & (len != '0) & (beat == len - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (pop) begin
            if (bus.m_last) begin
                beat <= '0;
            end else begin
                beat <= beat + LEN_W'(1);
            end
        end
    end
`else
    logic len_unused;

    assign len_unused = ^len;
    assign bus.m_last = 1'b0;
`endif

endmodule
